// File: rtl/vec_fifo_pkg.sv
// Shared types and helpers for the FIFO-to-s8-row-vector unpacker.
package vec_fifo_pkg;

    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_EMIT} rd_state_t;

    typedef logic [35:0] fifo_word_t;

    function automatic int words_per_row(input int vlen);
        return vlen / 4;
    endfunction

endpackage

// File: rtl/s8_word_unpack.sv
// Splits a {mask,data} FIFO word into four s8 bytes; masked-off bytes read as zero.
module s8_word_unpack
    import vec_fifo_pkg::*;
(
    input  fifo_word_t        word,
    output logic signed [7:0] bytes [4]
);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            bytes[k] = word[32 + k] ? $signed(word[8*k +: 8]) : 8'sd0;
        end
    end

endmodule

// File: rtl/fifo_to_vec_s8.sv
// Rebuilds VLEN-byte s8 row vectors from 4-byte FIFO words into a two-bank ping-pong
// store and replays each closed bank as a burst of rows.
//
// state  | meaning
// R_IDLE | waiting for rd_bank to be closed by the write side
// R_LOAD | registering row 0 and the bank row count
// R_EMIT | presenting rows; advances one row per accepted handshake
module fifo_to_vec_s8
    import vec_fifo_pkg::*;
#(
    parameter int VLEN = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_mask,
    input  logic [31:0]             in_data,
    input  logic                    in_switch_row,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [7:0]       out_vec_s8 [VLEN],
    output logic                    out_last,
    output logic [$clog2(VLEN):0]   out_rows,
    output logic                    fifo_full_flag
);

    localparam int WPR = words_per_row(VLEN);
    localparam int RW  = $clog2(VLEN);
    localparam int CW  = $clog2(WPR);
    localparam logic [RW:0] ROW_ONE = (RW+1)'(1);

    logic signed [7:0] mem [2][VLEN][VLEN];
    logic signed [7:0] bytes [4];
    logic [1:0]        full;
    logic [RW:0]       rows_q [2];
    logic              wr_bank, rd_bank, rdy_en;
    logic [RW-1:0]     row_ptr, rd_row;
    logic [CW-1:0]     col_ptr;
    logic              out_last_q;
    logic              wr_fire, row_close, bank_close, rd_release;
    rd_state_t         state, state_nxt;

    s8_word_unpack u_unpack (
        .word  ({in_mask, in_data}),
        .bytes (bytes)
    );

    assign in_ready       = rdy_en & ~full[wr_bank];
    assign fifo_full_flag = &full;
    assign wr_fire        = in_valid & in_ready;
    assign row_close      = (col_ptr == CW'(WPR - 1)) | in_switch_row | in_last;
    assign bank_close     = wr_fire & (in_last | (row_close & (row_ptr == RW'(VLEN - 1))));
    assign rd_release     = (state == R_EMIT) & out_ready & out_last_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdy_en  <= 1'b0;
            wr_bank <= 1'b0;
            row_ptr <= '0;
            col_ptr <= '0;
            full    <= '0;
            for (int b = 0; b < 2; b++) rows_q[b] <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (wr_fire) begin
                if (bank_close) begin
                    wr_bank          <= ~wr_bank;
                    row_ptr          <= '0;
                    col_ptr          <= '0;
                    rows_q[wr_bank]  <= {1'b0, row_ptr} + ROW_ONE;
                end else if (row_close) begin
                    row_ptr <= row_ptr + RW'(1);
                    col_ptr <= '0;
                end else begin
                    col_ptr <= col_ptr + CW'(1);
                end
            end
            // A closing write and a releasing read always target different banks.
            for (int b = 0; b < 2; b++) begin
                if (bank_close && (wr_bank == 1'(b)))
                    full[b] <= 1'b1;
                else if (rd_release && (rd_bank == 1'(b)))
                    full[b] <= 1'b0;
            end
        end
    end

    // First word of a row clears the rest of it, so short rows read back zero-padded.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int c = 0; c < VLEN; c++) begin
                if (CW'(c / 4) == col_ptr)
                    mem[wr_bank][row_ptr][c] <= bytes[2'(c % 4)];
                else if (col_ptr == '0)
                    mem[wr_bank][row_ptr][c] <= 8'sd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= R_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            R_IDLE:  if (full[rd_bank]) state_nxt = R_LOAD;
            R_LOAD:  state_nxt = R_EMIT;
            R_EMIT:  if (rd_release) state_nxt = R_IDLE;
            default: state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == R_EMIT);
        out_last  = out_last_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_bank    <= 1'b0;
            rd_row     <= '0;
            out_rows   <= '0;
            out_last_q <= 1'b0;
            for (int c = 0; c < VLEN; c++) out_vec_s8[c] <= 8'sd0;
        end else begin
            case (state)
                R_LOAD: begin
                    for (int c = 0; c < VLEN; c++) out_vec_s8[c] <= mem[rd_bank][0][c];
                    out_rows   <= rows_q[rd_bank];
                    out_last_q <= (rows_q[rd_bank] == ROW_ONE);
                    rd_row     <= RW'(1);
                end
                R_EMIT: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            rd_bank    <= ~rd_bank;
                            out_last_q <= 1'b0;
                        end else begin
                            for (int c = 0; c < VLEN; c++) out_vec_s8[c] <= mem[rd_bank][rd_row][c];
                            out_last_q <= ({1'b0, rd_row} == (out_rows - ROW_ONE));
                            rd_row     <= rd_row + RW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_to_vec_s8.sv
// Randomized bench for fifo_to_vec_s8 against a row/batch queue model of the unpacker.
module tb_fifo_to_vec_s8;

    localparam int VLEN = 16;
    localparam int WPR  = VLEN / 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid, in_ready, in_switch_row, in_last;
    logic [3:0]        in_mask;
    logic [31:0]       in_data;
    logic              out_valid, out_ready, out_last, fifo_full_flag;
    logic signed [7:0] out_vec_s8 [VLEN];
    logic [4:0]        out_rows;

    always #5 clk = ~clk;

    fifo_to_vec_s8 #(.VLEN(VLEN)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_mask        (in_mask),
        .in_data        (in_data),
        .in_switch_row  (in_switch_row),
        .in_last        (in_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_vec_s8     (out_vec_s8),
        .out_last       (out_last),
        .out_rows       (out_rows),
        .fifo_full_flag (fifo_full_flag)
    );

    typedef struct {
        logic [8*VLEN-1:0] vec;
        logic              last;
        int                rows;
    } exp_t;

    exp_t              exp_q [$];
    logic [8*VLEN-1:0] batch [$];
    logic [8*VLEN-1:0] cur_row = '0;
    int                cur_col = 0;
    int                n_chk = 0;
    int                n_bad = 0;
    int                ready_mode = 0;

    task automatic chk(input string tag, input logic [8*VLEN-1:0] got, input logic [8*VLEN-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8*VLEN-1:0] pack_out();
        logic [8*VLEN-1:0] v;
        for (int i = 0; i < VLEN; i++) v[8*i +: 8] = out_vec_s8[i];
        return v;
    endfunction

    task automatic model_word(input logic [3:0] m, input logic [31:0] d, input logic sw, input logic lst);
        for (int k = 0; k < 4; k++)
            cur_row[(cur_col*4 + k)*8 +: 8] = m[k] ? d[8*k +: 8] : 8'h00;
        cur_col++;
        if (cur_col == WPR || sw || lst) begin
            batch.push_back(cur_row);
            cur_row = '0;
            cur_col = 0;
            if (lst || batch.size() == VLEN) begin
                for (int i = 0; i < batch.size(); i++)
                    exp_q.push_back('{vec: batch[i], last: (i == batch.size() - 1), rows: batch.size()});
                batch.delete();
            end
        end
    endtask

    task automatic model_reset();
        cur_row = '0;
        cur_col = 0;
        batch.delete();
        exp_q.delete();
    endtask

    task automatic send(input logic [3:0] m, input logic [31:0] d, input logic sw, input logic lst);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1; in_mask = m; in_data = d; in_switch_row = sw; in_last = lst;
        while (!in_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_word(m, d, sw, lst);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_accept(input bit need_last);
        int t = 0;
        logic found = 1'b0;
        while (t < 3000 && !found) begin
            @(negedge clk);
            found = out_valid && out_ready && (!need_last || out_last);
            t++;
        end
        chk("accept_timeout", found, 1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Row checker: every accepted row matches the model; held rows stay stable.
    initial begin
        logic              pend;
        logic [8*VLEN-1:0] pvec, v;
        logic              plast;
        exp_t              e;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                pend = 1'b0;
            end else begin
                v = pack_out();
                if (pend) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_vec", v, pvec);
                    chk("hold_last", out_last, plast);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_row", out_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("row_vec", v, e.vec);
                        chk("row_last", out_last, e.last);
                        chk("row_count", out_rows, e.rows);
                    end
                    pend = 1'b0;
                end else begin
                    pend = out_valid;
                end
                pvec  = v;
                plast = out_last;
            end
        end
    end

    initial begin
        int nw;
        rstn = 1'b0;
        in_valid = 1'b0; in_mask = '0; in_data = '0; in_switch_row = 1'b0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_rows", out_rows, 0);
        chk("rst_full_flag", fifo_full_flag, 0);
        chk("rst_out_vec", pack_out(), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_rst", in_ready, 1);

        // four full rows, then latency and back-to-back streaming
        ready_mode = 0;
        for (int w = 0; w < 16; w++) send(4'hF, $urandom, 1'b0, w == 15);
        @(negedge clk); chk("lat_c0", out_valid, 0);
        @(negedge clk); chk("lat_c1", out_valid, 0);
        @(negedge clk); chk("lat_c2", out_valid, 1);
        chk("t1_rows", out_rows, 4);
        for (int r = 1; r < 4; r++) begin
            @(negedge clk);
            chk("stream_valid", out_valid, 1);
        end
        @(negedge clk); chk("burst_end", out_valid, 0);

        // short row with partial mask then a closing word
        send(4'hF, $urandom, 1'b0, 1'b0);
        send(4'b0111, $urandom, 1'b1, 1'b0);
        send(4'hF, $urandom, 1'b0, 1'b1);
        wait_drain();

        // stall for several cycles mid-burst
        for (int w = 0; w < 16; w++) send(4'hF, $urandom, 1'b0, w == 15);
        wait_accept(1'b0);
        ready_mode = 2;
        repeat (6) @(negedge clk);
        ready_mode = 0;
        wait_drain();

        // both banks closed with downstream stalled
        ready_mode = 2;
        for (int w = 0; w < 8; w++) send(4'hF, $urandom, 1'b0, w == 7);
        for (int w = 0; w < 3; w++) send($urandom, $urandom, 1'b1, w == 2);
        repeat (3) @(negedge clk);
        chk("both_full_flag", fifo_full_flag, 1);
        chk("both_full_ready", in_ready, 0);
        ready_mode = 0;
        wait_accept(1'b1);
        chk("ready_before_release", in_ready, 0);
        @(negedge clk);
        chk("ready_after_release", in_ready, 1);
        wait_drain();

        // sixteen rows auto-close the bank, next word starts a new one
        for (int r = 0; r < 16; r++) send(4'hF, $urandom, 1'b1, 1'b0);
        send(4'hF, $urandom, 1'b0, 1'b1);
        wait_drain();

        // async reset while a burst is presented
        ready_mode = 2;
        for (int r = 0; r < 3; r++) send(4'hF, $urandom, 1'b1, r == 2);
        begin
            int t = 0;
            while (!out_valid && t < 100) begin @(negedge clk); t++; end
        end
        chk("pre_rst_valid", out_valid, 1);
        #2 rstn = 1'b0;
        #1 chk("async_rst_valid", out_valid, 0);
        chk("async_rst_full", fifo_full_flag, 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        ready_mode = 0;
        send(4'hF, $urandom, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_rows", out_rows, 1);
        chk("post_rst_last", out_last, 1);
        wait_drain();

        // random batches with random backpressure
        ready_mode = 1;
        for (int b = 0; b < 20; b++) begin
            nw = $urandom_range(1, 20);
            for (int w = 0; w < nw; w++)
                send(4'($urandom), $urandom, 1'($urandom_range(0, 3) == 0), w == nw - 1);
        end
        wait_drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
